// File: rtl/var_delay_line_mem.sv
// Variable-length multi-channel delay line built on a circular buffer.
// Delay is counted in enabled cycles; dout is gated to zero until the buffer holds len_o samples.
module var_delay_line_mem #(
  parameter int DW       = 8,
  parameter int CH       = 1,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 5,
  localparam int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             len_ld,
  input  logic [LW-1:0]    len_i,
  input  logic [CH*DW-1:0] din,
  output logic [CH*DW-1:0] dout,
  output logic             dout_vld,
  output logic [LW-1:0]    len_o
);

  localparam int PW = $clog2(MAX_LEN);
  localparam int AW = LW + 1;
  localparam int WW = CH * DW;

  // Requested length forced into 1..MAX_LEN.
  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] req);
    logic [LW-1:0] res;
    if (req == {LW{1'b0}}) begin
      res = LW'(1);
    end else if (req > LW'(MAX_LEN)) begin
      res = LW'(MAX_LEN);
    end else begin
      res = req;
    end
    return res;
  endfunction

  logic [WW-1:0] mem_r [MAX_LEN];
  logic [PW-1:0] wptr_r;
  logic [PW-1:0] wptr_nxt_s;
  logic [LW-1:0] fill_r;
  logic [LW-1:0] fill_nxt_s;
  logic [LW-1:0] len_r;
  logic [WW-1:0] dout_r;
  logic          vld_r;
  logic          step_s;
  logic          clr_s;
  logic [AW-1:0] rd_sum_s;
  logic [AW-1:0] rd_wrap_s;
  logic [PW-1:0] rd_addr_s;
  logic [WW-1:0] rd_data_s;

  // Next pointer/fill and the read tap: the sample written len-1 enabled edges ago.
  always_comb begin
    step_s     = en & ~flush & ~len_ld;
    clr_s      = flush | len_ld;
    wptr_nxt_s = (wptr_r == PW'(MAX_LEN - 1)) ? {PW{1'b0}} : wptr_r + PW'(1);
    fill_nxt_s = (fill_r == LW'(MAX_LEN)) ? fill_r : fill_r + LW'(1);
    rd_sum_s   = AW'(wptr_r) + AW'(MAX_LEN) + AW'(1) - AW'(len_r);
    if (rd_sum_s >= AW'(MAX_LEN)) begin
      rd_wrap_s = rd_sum_s - AW'(MAX_LEN);
    end else begin
      rd_wrap_s = rd_sum_s;
    end
    rd_addr_s = rd_wrap_s[PW-1:0];
    // A length of one reads the word being written this edge, so bypass the memory.
    if (len_r == LW'(1)) begin
      rd_data_s = din;
    end else begin
      rd_data_s = mem_r[rd_addr_s];
    end
  end

  // Sample storage; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst_n && step_s) begin
      mem_r[wptr_r] <= din;
    end
  end

  // Pointer, fill level, active length and registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r <= {PW{1'b0}};
      fill_r <= {LW{1'b0}};
      len_r  <= LW'(INIT_LEN);
      dout_r <= {WW{1'b0}};
      vld_r  <= 1'b0;
    end else if (clr_s) begin
      fill_r <= {LW{1'b0}};
      dout_r <= {WW{1'b0}};
      vld_r  <= 1'b0;
      if (len_ld) begin
        len_r <= clamp_len(len_i);
      end
    end else if (step_s) begin
      wptr_r <= wptr_nxt_s;
      fill_r <= fill_nxt_s;
      vld_r  <= (fill_nxt_s >= len_r);
      dout_r <= (fill_nxt_s >= len_r) ? rd_data_s : {WW{1'b0}};
    end
  end

  assign dout     = dout_r;
  assign dout_vld = vld_r;
  assign len_o    = len_r;

endmodule

// File: tb/tb_var_delay_line_mem.sv
// Randomized self-checking bench for var_delay_line_mem (DW=8, CH=2, MAX_LEN=8, INIT_LEN=5).
// Reference model keeps the history of accepted samples since the last clear and indexes it.
module tb_var_delay_line_mem;

  localparam int DW = 8;
  localparam int CH = 2;
  localparam int ML = 8;
  localparam int IL = 5;
  localparam int LW = $clog2(ML + 1);

  logic              clk;
  logic              rst_n;
  logic              en;
  logic              flush;
  logic              len_ld;
  logic [LW-1:0]     len_i;
  logic [CH*DW-1:0]  din;
  logic [CH*DW-1:0]  dout;
  logic              dout_vld;
  logic [LW-1:0]     len_o;

  int errors = 0;
  int checks = 0;

  logic [15:0] hist[$];
  int          len_m;

  var_delay_line_mem #(.DW(DW), .CH(CH), .MAX_LEN(ML), .INIT_LEN(IL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .len_ld(len_ld),
    .len_i(len_i), .din(din), .dout(dout), .dout_vld(dout_vld), .len_o(len_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    len_m = IL;
  endtask

  task automatic check_model(input string tag);
    int n;
    logic [15:0] ed;
    logic ev;
    n  = hist.size();
    ev = (n >= len_m);
    ed = ev ? hist[n - len_m] : 16'h0000;
    check_val({tag, "_vld"}, {31'd0, dout_vld}, {31'd0, ev});
    check_val({tag, "_dout"}, {16'd0, dout}, {16'd0, ed});
    check_val({tag, "_len"}, {28'd0, len_o}, len_m);
  endtask

  // One clock: drive at negedge, update model at posedge, compare 1 time unit later.
  task automatic step(input logic e, input logic f, input logic l, input logic [LW-1:0] li,
                      input logic [15:0] d, input string tag);
    @(negedge clk);
    en = e; flush = f; len_ld = l; len_i = li; din = d;
    @(posedge clk);
    if (f || l) begin
      hist.delete();
      if (l) len_m = (li == 0) ? 1 : ((li > ML) ? ML : int'(li));
    end else if (e) begin
      hist.push_back(d);
    end
    #1;
    check_model(tag);
  endtask

  task automatic fill_pattern(input string tag);
    logic [7:0] n8;
    for (int n = 1; n <= 12; n++) begin
      n8 = 8'(n);
      step(1'b1, 1'b0, 1'b0, 4'd0, {8'h80 + n8, n8}, tag);
      if (n == 4) check_val({tag, "_e4_vld"}, {31'd0, dout_vld}, 32'd0);
      if (n == 5) begin
        check_val({tag, "_e5_vld"}, {31'd0, dout_vld}, 32'd1);
        check_val({tag, "_e5_dout"}, {16'd0, dout}, 32'h8101);
      end
      if (n == 7) check_val({tag, "_e7_dout"}, {16'd0, dout}, 32'h8303);
    end
  endtask

  initial begin
    logic [15:0] held;
    rst_n = 1'b0; en = 1'b0; flush = 1'b0; len_ld = 1'b0; len_i = '0; din = '0;
    model_reset();
    #12;
    check_val("rst_dout", {16'd0, dout}, 32'd0);
    check_val("rst_vld", {31'd0, dout_vld}, 32'd0);
    check_val("rst_len", {28'd0, len_o}, IL);
    @(negedge clk);
    rst_n = 1'b1;

    fill_pattern("fill");

    // Enable gap: outputs frozen while din keeps moving.
    held = dout;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 4'd0, 16'($urandom), "gap");
      check_val("gap_hold", {16'd0, dout}, {16'd0, held});
    end
    for (int n = 13; n <= 17; n++)
      step(1'b1, 1'b0, 1'b0, 4'd0, {8'h80 + 8'(n), 8'(n)}, "resume");
    check_val("resume_dout", {16'd0, dout}, 32'h8D0D);

    // Length 1: same-edge bypass.
    step(1'b0, 1'b0, 1'b1, 4'd1, 16'h0000, "ld1");
    step(1'b1, 1'b0, 1'b0, 4'd0, 16'h1234, "len1");
    check_val("len1_dout", {16'd0, dout}, 32'h1234);
    check_val("len1_vld", {31'd0, dout_vld}, 32'd1);

    // Clamping, then an 8-deep stream spanning several wraps.
    step(1'b0, 1'b0, 1'b1, 4'd0, 16'h0000, "ld0");
    check_val("clamp_lo", {28'd0, len_o}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 4'd12, 16'h0000, "ld12");
    check_val("clamp_hi", {28'd0, len_o}, 32'd8);
    for (int i = 0; i < 40; i++)
      step(1'b1, 1'b0, 1'b0, 4'd0, 16'($urandom), "wrap");

    // Flush and len_ld together with en mid-stream.
    step(1'b1, 1'b1, 1'b1, 4'd3, 16'hBEEF, "fl_ld");
    check_val("fl_ld_dout", {16'd0, dout}, 32'd0);
    check_val("fl_ld_len", {28'd0, len_o}, 32'd3);
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 4'd0, 16'h0A00 + 16'(i), "post_fl");
      check_val("post_fl_vld", {31'd0, dout_vld}, (i == 3) ? 32'd1 : 32'd0);
    end
    check_val("post_fl_dout", {16'd0, dout}, 32'h0A01);

    // Random traffic with occasional flushes and length loads.
    for (int i = 0; i < 400; i++) begin
      automatic int r = $urandom_range(0, 99);
      step(($urandom_range(0, 3) != 0), (r < 3), (r >= 97),
           4'($urandom_range(0, 15)), 16'($urandom), "rand");
    end

    // Asynchronous reset between edges while streaming.
    step(1'b0, 1'b0, 1'b1, 4'd4, 16'h0000, "pre_rst_ld");
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b0, 1'b0, 4'd0, 16'($urandom), "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_dout", {16'd0, dout}, 32'd0);
    check_val("arst_vld", {31'd0, dout_vld}, 32'd0);
    check_val("arst_len", {28'd0, len_o}, IL);
    model_reset();
    @(negedge clk);
    en = 1'b1; flush = 1'b1; len_ld = 1'b1;
    @(posedge clk);
    #1;
    check_val("rst_ignore_len", {28'd0, len_o}, IL);
    @(negedge clk);
    en = 1'b0; flush = 1'b0; len_ld = 1'b0;
    rst_n = 1'b1;
    fill_pattern("refill");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/var_delay_line_mem.md
VAR_DELAY_LINE_MEM -- requirements
Module: var_delay_line_mem

Interface
REQ-001 Parameter DW, default 8, bit width of one channel sample.
REQ-002 Parameter CH, default 1, number of channels; all channels share the pointer, length and enable.
REQ-003 Parameter MAX_LEN, default 16, memory depth and maximum delay in enabled cycles; legal range is 2 or more.
REQ-004 Parameter INIT_LEN, default 5, delay length after reset; legal range is 1..MAX_LEN.
REQ-005 Derived width LW = $clog2(MAX_LEN+1).
REQ-006 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-007 Port rst_n, input, 1, asynchronous active-low reset.
REQ-008 Port en, input, 1, advance enable; one enabled edge is one delay step.
REQ-009 Port flush, input, 1, synchronous clear of the fill state.
REQ-010 Port len_ld, input, 1, synchronous load of len_i.
REQ-011 Port len_i, input, LW, requested delay length.
REQ-012 Port din, input, CH*DW, input samples; channel c occupies bits [c*DW +: DW].
REQ-013 Port dout, output, CH*DW, delayed samples.
REQ-014 Port dout_vld, output, 1, high when dout holds a genuinely delayed sample.
REQ-015 Port len_o, output, LW, active delay length.

Function
REQ-016 Storage is a circular buffer of MAX_LEN words of CH*DW bits, addressed by a write pointer that wraps modulo MAX_LEN; memory contents are not reset.
REQ-017 An enabled edge is a rising clk edge with en=1, flush=0 and len_ld=0.
- din is written at the write pointer.
- The pointer advances by one, wrapping from MAX_LEN-1 to 0.
- The fill counter increments and saturates at MAX_LEN.
REQ-018 Delay rule: after the n-th enabled edge, counted from the last reset, flush or len_ld, dout equals the din sampled at enabled edge n-len_o+1; this is identical to a chain of len_o enable-gated registers.
REQ-019 With len_o=1, dout equals the din of the same enabled edge; this requires a write-to-read bypass.
REQ-020 dout_vld is 1 after an enabled edge when fill >= len_o, and 0 otherwise.
REQ-021 While dout_vld=0, dout is all zeros.
REQ-022 On an edge with en=0 (and no flush or len_ld): dout, dout_vld, the pointer, the fill counter and memory all hold.
REQ-023 On an edge with flush=1:
- The fill counter is set to 0.
- dout_vld is set to 0 and dout to 0.
- The en for that edge is discarded: no write, no pointer advance.
REQ-024 On an edge with len_ld=1, len_o takes len_i clamped to the range 1..MAX_LEN:
- len_i=0 loads 1.
- len_i>MAX_LEN loads MAX_LEN.
- All flush side effects of REQ-023 also apply.
REQ-025 flush and len_ld asserted on the same edge: both take effect; the en for that edge is discarded.
REQ-026 The pointer wraps seamlessly; the delay rule holds across any number of wraps.
REQ-027 Output latency equals the length rule exactly; there is no extra pipeline stage.

Reset
REQ-028 While rst_n=0, all of the following hold immediately and asynchronously:
- dout=0, dout_vld=0, len_o=INIT_LEN.
- Write pointer=0, fill counter=0.
REQ-029 Reset may assert mid-stream; after release the block behaves exactly as after power-up reset.
REQ-030 en, flush and len_ld are ignored while rst_n=0.

Verification (DW=8, CH=2, MAX_LEN=8, INIT_LEN=5)
REQ-031 Continuous fill: release reset, hold en=1, drive ch0=n and ch1=0x80+n on enabled edge n -> dout_vld=0 after edges 1-4; after edge 5, dout_vld=1 and dout={0x81,0x01}; then {0x82,0x02}, {0x83,0x03}, and so on.
REQ-032 Enable gap: during the steady stream, drop en for 3 cycles while din keeps changing -> dout and dout_vld frozen during the gap; the sequence resumes with no sample lost or duplicated.
REQ-033 Length change to 1: pulse len_ld with len_i=1, then give enabled edges with din=0x1234 -> len_o=1; after the first enabled edge, dout_vld=1 and dout=0x1234.
REQ-034 Clamp and wrap: len_ld with len_i=0 -> len_o=1; len_ld with len_i=12 -> len_o=8; stream 40 samples -> dout lags din by 7 enabled edges (8-deep chain) across 5 pointer wraps.
REQ-035 Flush and simultaneous events: assert flush and len_ld (len_i=3) together with en=1 mid-stream -> next cycle dout=0, dout_vld=0, len_o=3, no write; dout_vld rises after the 3rd subsequent enabled edge.
REQ-036 Async reset mid-operation: pull rst_n low between clock edges while streaming -> dout=0, dout_vld=0 and len_o=5 with no clock edge required; after release, scenario REQ-031 repeats exactly.
